reg_writeback: RTL and testbench

Write-back unit for the MIPS core and the single initiator of the register file write port (WriteReg/WriteData/RegWrite). It merges two result sources onto that port: the in-order ALU pipe, which cannot stall, and long-latency results (multiply/divide, loads), which use a valid/ready handshake and are buffered in a small FIFO. It also keeps a 32-bit busy scoreboard that decode uses to stall on registers with an outstanding long-latency write.

---
 rtl/reg_writeback_pkg.sv | 21 ++
 rtl/reg_writeback_if.sv | 14 +
 rtl/reg_writeback_fifo.sv | 51 +++++
 rtl/reg_writeback.sv | 108 ++++++++++
 tb/tb_reg_writeback.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_writeback_pkg.sv
// Shared widths and the long-result record for the MIPS write-back slice.
// Consumers import mips_wb_pkg::*.
package mips_wb_pkg;

  localparam int DATA_W         = 32;
  localparam int ADDR_W         = 5;
  localparam int DEF_FIFO_DEPTH = 2;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } WbResult_t;

  // Register 0 is hard-wired in the register file, so writes to it carry no information.
  function automatic logic isLiveReg(input logic [ADDR_W-1:0] r);
    return r != ZERO_REG;
  endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// Valid/ready channel carrying long-latency results (mul/div, loads)
// from their producers into the write-back unit.
interface reg_writeback_if;
  import mips_wb_pkg::*;

  logic              LongValid;
  logic              LongReady;
  logic [ADDR_W-1:0] LongReg;
  logic [DATA_W-1:0] LongData;

  modport master (output LongValid, output LongReg, output LongData, input LongReady);
  modport slave  (input LongValid, input LongReg, input LongData, output LongReady);

endinterface

// File: rtl/reg_writeback_fifo.sv
// Small synchronous FIFO for long results; pointers carry one extra wrap bit
// so full and empty are told apart without a separate counter.
module wb_result_fifo
  import mips_wb_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  WbResult_t pushData,
  output WbResult_t head,
  output logic      full,
  output logic      empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] wrPtr;
  logic [PW:0] rdPtr;
  WbResult_t   mem [DEPTH];
  logic        doPush;
  logic        doPop;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[PW] != rdPtr[PW]) && (wrPtr[PW-1:0] == rdPtr[PW-1:0]);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign head   = mem[rdPtr[PW-1:0]];

  // Pointer advance and storage write; reset also clears storage so head never shows stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (doPush) begin
        mem[wrPtr[PW-1:0]] <= pushData;
        wrPtr              <= wrPtr + {{PW{1'b0}}, 1'b1};
      end
      if (doPop) begin
        rdPtr <= rdPtr + {{PW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Register-file write-back: ALU results have priority, long results drain from a FIFO,
// and a busy scoreboard tracks pending long writes. Optional bypass: REG_WRITEBACK_FWD_EN.
module reg_writeback
  import mips_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              AluValid,
  input  logic [ADDR_W-1:0] AluReg,
  input  logic [DATA_W-1:0] AluData,
  reg_writeback_if.slave    longIf,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueReg,
  output logic [31:0]       Busy,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite
`ifdef REG_WRITEBACK_FWD_EN
  ,
  output logic              FwdValid,
  output logic [ADDR_W-1:0] FwdReg,
  output logic [DATA_W-1:0] FwdData
`endif
);

  WbResult_t   fifoHead;
  WbResult_t   selRes;
  logic        fifoFull;
  logic        fifoEmpty;
  logic        pushFifo;
  logic        popFifo;
  logic        selValid;
  logic [31:0] busyNext;

  // LongReady depends only on the registered FIFO pointers, never on this cycle's pop.
  assign longIf.LongReady = ~fifoFull;
  assign pushFifo = longIf.LongValid & ~fifoFull & isLiveReg(longIf.LongReg);

  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (pushFifo),
    .pop      (popFifo),
    .pushData ({longIf.LongReg, longIf.LongData}),
    .head     (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  // Source selection: a live ALU result wins, otherwise drain the FIFO head.
  always_comb begin
    selValid = 1'b0;
    selRes   = '0;
    popFifo  = 1'b0;
    if (AluValid && isLiveReg(AluReg)) begin
      selValid = 1'b1;
      selRes   = '{idx: AluReg, data: AluData};
    end else if (!fifoEmpty) begin
      selValid = 1'b1;
      selRes   = fifoHead;
      popFifo  = 1'b1;
    end else begin
      selValid = 1'b0;
    end
  end

  // Scoreboard update: pop clears first so a same-cycle issue to that register re-sets it.
  always_comb begin
    busyNext = Busy;
    if (popFifo) begin
      busyNext[fifoHead.idx] = 1'b0;
    end else begin
      busyNext = Busy;
    end
    if (IssueValid && isLiveReg(IssueReg)) begin
      busyNext[IssueReg] = 1'b1;
    end else begin
      busyNext[0] = 1'b0;
    end
    busyNext[0] = 1'b0;
  end

  // Write-port and scoreboard registers share one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
      Busy      <= 32'd0;
    end else begin
      RegWrite <= selValid;
      Busy     <= busyNext;
      if (selValid) begin
        WriteReg  <= selRes.idx;
        WriteData <= selRes.data;
      end
    end
  end

`ifdef REG_WRITEBACK_FWD_EN
  assign FwdValid = selValid;
  assign FwdReg   = selRes.idx;
  assign FwdData  = selRes.data;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: queue-based reference model checked every cycle,
// plus hand-computed spot checks for each scenario.
module tb_reg_writeback;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        AluValid;
  logic [4:0]  AluReg;
  logic [31:0] AluData;
  logic        IssueValid;
  logic [4:0]  IssueReg;
  logic [31:0] Busy;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        RegWrite;
`ifdef REG_WRITEBACK_FWD_EN
  logic        FwdValid;
  logic [4:0]  FwdReg;
  logic [31:0] FwdData;
`endif

  reg_writeback_if lif();

  reg_writeback #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .AluValid   (AluValid),
    .AluReg     (AluReg),
    .AluData    (AluData),
    .longIf     (lif),
    .IssueValid (IssueValid),
    .IssueReg   (IssueReg),
    .Busy       (Busy),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .RegWrite   (RegWrite)
`ifdef REG_WRITEBACK_FWD_EN
    ,
    .FwdValid   (FwdValid),
    .FwdReg     (FwdReg),
    .FwdData    (FwdData)
`endif
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;
  bit chkOn  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted long results wait in a queue in arrival order.
  logic [36:0] q[$];
  logic        mWr;
  logic [4:0]  mReg;
  logic [31:0] mData;
  logic [31:0] mBusy;
  logic        mReady;

  function automatic logic [31:0] nextBusy(input logic [31:0] b, input bit clrV, input logic [4:0] clrR,
                                           input bit setV, input logic [4:0] setR);
    if (clrV) b[clrR] = 1'b0;
    if (setV && setR != 5'd0) b[setR] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      mWr    <= 1'b0;
      mReg   <= 5'd0;
      mData  <= 32'd0;
      mBusy  <= 32'd0;
      mReady <= 1'b1;
    end else begin
      mBusy <= nextBusy(mBusy, !(AluValid && AluReg != 5'd0) && q.size() != 0,
                        (q.size() != 0) ? q[0][36:32] : 5'd0, IssueValid, IssueReg);
      if (AluValid && AluReg != 5'd0) begin
        mWr   <= 1'b1;
        mReg  <= AluReg;
        mData <= AluData;
      end else if (q.size() != 0) begin
        mWr   <= 1'b1;
        mReg  <= q[0][36:32];
        mData <= q[0][31:0];
        q.pop_front();
      end else begin
        mWr <= 1'b0;
      end
      if (lif.LongValid && mReady && lif.LongReg != 5'd0) q.push_back({lif.LongReg, lif.LongData});
      mReady <= (q.size() < DEPTH);
    end
  end

  // Every-cycle comparison of the DUT against the model.
  bit          fwdOk = 1'b0;
  logic        pV;
  logic [4:0]  pR;
  logic [31:0] pD;
  initial begin
    wait (chkOn);
    forever begin
      @(negedge clk);
      check("RegWrite", {63'd0, RegWrite}, {63'd0, mWr});
      if (mWr) begin
        check("WriteReg", {59'd0, WriteReg}, {59'd0, mReg});
        check("WriteData", {32'd0, WriteData}, {32'd0, mData});
      end
      check("Busy", {32'd0, Busy}, {32'd0, mBusy});
      check("LongReady", {63'd0, lif.LongReady}, {63'd0, mReady});
`ifdef REG_WRITEBACK_FWD_EN
      if (fwdOk && rst_n) begin
        check("fwd_valid", {63'd0, RegWrite}, {63'd0, pV});
        if (pV) begin
          check("fwd_reg", {59'd0, WriteReg}, {59'd0, pR});
          check("fwd_data", {32'd0, WriteData}, {32'd0, pD});
        end
      end
      #3;
      pV    = FwdValid;
      pR    = FwdReg;
      pD    = FwdData;
      fwdOk = rst_n;
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    AluValid      = 1'b0; AluReg   = 5'd0; AluData  = 32'd0;
    lif.LongValid = 1'b0; lif.LongReg = 5'd0; lif.LongData = 32'd0;
    IssueValid    = 1'b0; IssueReg = 5'd0;
  endtask

  initial begin
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) step();
    chkOn = 1'b1;
    check("rst_we", {63'd0, RegWrite}, 64'd0);
    check("rst_busy", {32'd0, Busy}, 64'd0);
    check("rst_wdata", {32'd0, WriteData}, 64'd0);
    check("rst_ready", {63'd0, lif.LongReady}, 64'd1);
    rst_n = 1'b1;
    step();

    // ALU only
    AluValid = 1'b1; AluReg = 5'd5; AluData = 32'h1234; step();
    check("alu_we", {63'd0, RegWrite}, 64'd1);
    check("alu_reg", {59'd0, WriteReg}, 64'd5);
    check("alu_data", {32'd0, WriteData}, 64'h1234);
    AluReg = 5'd0; AluData = 32'hFFFF; step();
    check("alu_r0", {63'd0, RegWrite}, 64'd0);
    idle(); step();

    // ALU priority over a pending long result
    IssueValid = 1'b1; IssueReg = 5'd9; step();
    IssueValid = 1'b0;
    lif.LongValid = 1'b1; lif.LongReg = 5'd9; lif.LongData = 32'hAA;
    AluValid = 1'b1; AluReg = 5'd3; AluData = 32'h33; step();
    check("pri_r3", {59'd0, WriteReg}, 64'd3);
    check("pri_busy_a", {63'd0, Busy[9]}, 64'd1);
    lif.LongValid = 1'b0; AluReg = 5'd4; AluData = 32'h44; step();
    check("pri_r4", {59'd0, WriteReg}, 64'd4);
    AluReg = 5'd6; AluData = 32'h66; step();
    check("pri_r6", {59'd0, WriteReg}, 64'd6);
    check("pri_busy_b", {63'd0, Busy[9]}, 64'd1);
    AluValid = 1'b0; step();
    check("pri_we9", {63'd0, RegWrite}, 64'd1);
    check("pri_r9", {59'd0, WriteReg}, 64'd9);
    check("pri_d9", {32'd0, WriteData}, 64'hAA);
    check("pri_busy_c", {63'd0, Busy[9]}, 64'd0);
    step();
    check("pri_idle", {63'd0, RegWrite}, 64'd0);

    // Backpressure with the ALU busy every cycle
    IssueValid = 1'b1; IssueReg = 5'd10; AluValid = 1'b1; AluReg = 5'd1; AluData = 32'd1; step();
    IssueReg = 5'd11; lif.LongValid = 1'b1; lif.LongReg = 5'd10; lif.LongData = 32'h100;
    AluReg = 5'd2; step();
    check("bp_ready1", {63'd0, lif.LongReady}, 64'd1);
    IssueValid = 1'b0; lif.LongReg = 5'd11; lif.LongData = 32'h200; AluReg = 5'd3; step();
    check("bp_full", {63'd0, lif.LongReady}, 64'd0);
    lif.LongValid = 1'b0; AluReg = 5'd4; step();
    check("bp_still_full", {63'd0, lif.LongReady}, 64'd0);
    check("bp_busy", {62'd0, Busy[11:10]}, 64'd3);
    AluValid = 1'b0; step();
    check("bp_r10", {59'd0, WriteReg}, 64'd10);
    check("bp_d10", {32'd0, WriteData}, 64'h100);
    check("bp_ready2", {63'd0, lif.LongReady}, 64'd1);
    check("bp_busy10", {62'd0, Busy[11:10]}, 64'd2);
    step();
    check("bp_r11", {59'd0, WriteReg}, 64'd11);
    check("bp_d11", {32'd0, WriteData}, 64'h200);
    check("bp_busy11", {63'd0, Busy[11]}, 64'd0);
    step();

    // Scoreboard race: issue and pop of reg 7 in one cycle
    IssueValid = 1'b1; IssueReg = 5'd7; step();
    IssueValid = 1'b0; lif.LongValid = 1'b1; lif.LongReg = 5'd7; lif.LongData = 32'h77; step();
    lif.LongValid = 1'b0; IssueValid = 1'b1; IssueReg = 5'd7; step();
    check("race_we", {63'd0, RegWrite}, 64'd1);
    check("race_r7", {59'd0, WriteReg}, 64'd7);
    check("race_busy", {63'd0, Busy[7]}, 64'd1);
    IssueValid = 1'b0; step();
    check("race_busy_hold", {63'd0, Busy[7]}, 64'd1);

    // Long result to register 0 is dropped
    lif.LongValid = 1'b1; lif.LongReg = 5'd0; lif.LongData = 32'd5; step();
    lif.LongValid = 1'b0; step();
    check("r0_drop", {63'd0, RegWrite}, 64'd0);

    // Reset in the middle of traffic
    AluValid = 1'b1; AluReg = 5'd8; AluData = 32'd8;
    lif.LongValid = 1'b1; lif.LongReg = 5'd12; lif.LongData = 32'd12;
    IssueValid = 1'b1; IssueReg = 5'd12; step();
    lif.LongReg = 5'd13; step();
    rst_n = 1'b0; #1;
    check("mr_we", {63'd0, RegWrite}, 64'd0);
    check("mr_busy", {32'd0, Busy}, 64'd0);
    check("mr_reg", {59'd0, WriteReg}, 64'd0);
    check("mr_ready", {63'd0, lif.LongReady}, 64'd1);
    idle(); step(); step();
    rst_n = 1'b1; step();
    check("mr_rel1", {63'd0, RegWrite}, 64'd0);
    step();
    check("mr_rel2", {63'd0, RegWrite}, 64'd0);
    lif.LongValid = 1'b1; lif.LongReg = 5'd14; lif.LongData = 32'hE; step();
    lif.LongValid = 1'b0; step();
    check("mr_after_r", {59'd0, WriteReg}, 64'd14);
    check("mr_after_d", {32'd0, WriteData}, 64'hE);
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
